// File: rtl/cpu_trace_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_trace_pkg
//  Description : Shared types and constants for the CPU retirement-trace
//                buffer: entry layout, word indices, serializer states and
//                a word-select helper.
//  Ports       : none (package)
//  Revision    : 1.0 - initial release
// ============================================================================
package cpu_trace_pkg;

  localparam int TRACE_W = 96;
  localparam int DATA_W  = 32;

  // Word index presented on rd_word while an entry is streamed
  localparam logic [1:0] WORD_PC  = 2'd0;
  localparam logic [1:0] WORD_INS = 2'd1;
  localparam logic [1:0] WORD_WD  = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_W0   = 2'd1,
    ST_W1   = 2'd2,
    ST_W2   = 2'd3
  } trace_state_e;

  // Field order matches the {PC, instruction, write_data} entry layout
  typedef struct packed {
    logic [DATA_W-1:0] pc;
    logic [DATA_W-1:0] ins;
    logic [DATA_W-1:0] wd;
  } trace_entry_t;

  function automatic logic [DATA_W-1:0] trace_word(input trace_entry_t e,
                                                   input logic [1:0]   idx);
    case (idx)
      WORD_PC:  return e.pc;
      WORD_INS: return e.ins;
      default:  return e.wd;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/cpu_trace_buffer_if.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_trace_buffer_if
//  Description : Word-serial trace read port (valid/ready).
//                master : trace buffer side (drives valid/data/word/last)
//                slave  : host/bench reader side (drives ready)
//  Signals     : rd_valid, rd_ready, rd_data[31:0], rd_word[1:0], rd_last
//  Revision    : 1.0 - initial release
// ============================================================================
interface cpu_trace_buffer_if;

  logic        rd_valid;
  logic        rd_ready;
  logic [31:0] rd_data;
  logic [1:0]  rd_word;
  logic        rd_last;

  modport master (
    output rd_valid,
    output rd_data,
    output rd_word,
    output rd_last,
    input  rd_ready
  );

  modport slave (
    input  rd_valid,
    input  rd_data,
    input  rd_word,
    input  rd_last,
    output rd_ready
  );

endinterface
`default_nettype wire

// File: rtl/trace_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : trace_fifo
//  Description : Synchronous FIFO with first-word-fall-through head. Also
//                exposes the entry behind the head so a consumer can reload
//                on the same edge it pops. Push while full is honoured only
//                when a pop happens on the same edge.
//  Ports       : clk, rst (async, active-high), clear (sync flush),
//                push/push_data, pop, head, head_next, count, full, empty
//  Revision    : 1.0 - initial release
// ============================================================================
module trace_fifo #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4,
  parameter int WIDTH  = 96
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              push,
  input  logic [WIDTH-1:0]  push_data,
  input  logic              pop,
  output logic [WIDTH-1:0]  head,
  output logic [WIDTH-1:0]  head_next,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              empty
);

  logic [WIDTH-1:0]  mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic              push_ok;
  logic              pop_ok;

  assign full  = (count == (ADDR_W+1)'(DEPTH));
  assign empty = (count == '0);

  assign pop_ok  = pop & ~empty & ~clear;
  assign push_ok = push & (~full | pop_ok) & ~clear;

  assign head      = mem[rd_ptr];
  assign head_next = mem[rd_ptr + ADDR_W'(1)];

  // Storage needs no reset; validity is tracked by the pointers and count
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers are ADDR_W wide and DEPTH is a power of two, so they wrap freely
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + ADDR_W'(1);
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + ADDR_W'(1);
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + (ADDR_W+1)'(1);
        2'b01:   count <= count - (ADDR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/cpu_trace_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_trace_buffer
//  Description : Retirement-trace capture. Queues {PC, instruction,
//                write_data} for each retired instruction and streams the
//                entries word by word over a valid/ready read port.
//  Ports       : click, reset (async, active-high), cap_en, clear,
//                PCWre, RegWre, PC, instruction, write_data (CPU snoop),
//                rd (read port, master side), count, full, overflow
//  Revision    : 1.0 - initial release
// ============================================================================
module cpu_trace_buffer
  import cpu_trace_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic                click,
  input  logic                reset,
  input  logic                cap_en,
  input  logic                clear,
  input  logic                PCWre,
  input  logic                RegWre,
  input  logic [31:0]         PC,
  input  logic [31:0]         instruction,
  input  logic [31:0]         write_data,
  cpu_trace_buffer_if.master  rd,
  output logic [ADDR_W:0]     count,
  output logic                full,
  output logic                overflow
);

  trace_entry_t  cap_entry;
  trace_entry_t  head;
  trace_entry_t  head_next;
  trace_state_e  state;
  trace_state_e  state_nxt;
  logic [31:0]   data_q;
  logic [31:0]   data_nxt;
  logic [1:0]    word_idx;
  logic          capture;
  logic          handshake;
  logic          pop;
  logic          push;
  logic          fifo_empty;

  assign cap_entry = {PC, instruction, (RegWre ? write_data : 32'h0)};

  // clear discards any same-cycle capture outright
  assign capture   = cap_en & PCWre & ~clear;
  assign handshake = rd.rd_valid & rd.rd_ready;
  assign pop       = (state == ST_W2) & handshake & ~clear;
  // A full queue still accepts a capture when the head leaves on this edge
  assign push      = capture & (~full | pop);

  trace_fifo #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .WIDTH  (TRACE_W)
  ) u_fifo (
    .clk       (click),
    .rst       (reset),
    .clear     (clear),
    .push      (push),
    .push_data (cap_entry),
    .pop       (pop),
    .head      (head),
    .head_next (head_next),
    .count     (count),
    .full      (full),
    .empty     (fifo_empty)
  );

  // --------------------------------------------------------------------------
  // Serializer FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge click or posedge reset) begin
    if (reset) begin
      state  <= ST_IDLE;
      data_q <= '0;
    end else begin
      state  <= state_nxt;
      data_q <= data_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    data_nxt  = data_q;
    if (clear) begin
      state_nxt = ST_IDLE;
      data_nxt  = '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (!fifo_empty) begin
            state_nxt = ST_W0;
            data_nxt  = trace_word(head, WORD_PC);
          end
        end
        ST_W0: begin
          if (handshake) begin
            state_nxt = ST_W1;
            data_nxt  = trace_word(head, WORD_INS);
          end
        end
        ST_W1: begin
          if (handshake) begin
            state_nxt = ST_W2;
            data_nxt  = trace_word(head, WORD_WD);
          end
        end
        ST_W2: begin
          if (handshake) begin
            // The next head is either the entry already queued behind the
            // current one, or, when this was the only entry, the capture
            // arriving on this very edge (not yet in storage).
            if (count > (ADDR_W+1)'(1)) begin
              state_nxt = ST_W0;
              data_nxt  = trace_word(head_next, WORD_PC);
            end else if (push) begin
              state_nxt = ST_W0;
              data_nxt  = trace_word(cap_entry, WORD_PC);
            end else begin
              state_nxt = ST_IDLE;
              data_nxt  = '0;
            end
          end
        end
        default: begin
          state_nxt = ST_IDLE;
          data_nxt  = '0;
        end
      endcase
    end
  end

  always_comb begin
    word_idx = WORD_PC;
    case (state)
      ST_W1:   word_idx = WORD_INS;
      ST_W2:   word_idx = WORD_WD;
      default: word_idx = WORD_PC;
    endcase
  end

  assign rd.rd_valid = (state != ST_IDLE);
  assign rd.rd_data  = data_q;
  assign rd.rd_word  = word_idx;
  assign rd.rd_last  = rd.rd_valid & (word_idx == WORD_WD);

  // --------------------------------------------------------------------------
  // Sticky overflow: a capture was dropped because the queue was full
  // --------------------------------------------------------------------------
  always_ff @(posedge click or posedge reset) begin
    if (reset) begin
      overflow <= 1'b0;
    end else if (clear) begin
      overflow <= 1'b0;
    end else if (capture & full & ~pop) begin
      overflow <= 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cpu_trace_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cpu_trace_buffer
//  Description : Directed self-checking bench for cpu_trace_buffer.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cpu_trace_buffer;

  logic        click;
  logic        reset;
  logic        cap_en;
  logic        clear;
  logic        PCWre;
  logic        RegWre;
  logic [31:0] PC;
  logic [31:0] instruction;
  logic [31:0] write_data;
  logic [4:0]  count;
  logic        full;
  logic        overflow;

  int n_pass;
  int n_total;

  cpu_trace_buffer_if rd_if ();

  cpu_trace_buffer #(
    .DEPTH  (16),
    .ADDR_W (4)
  ) dut (
    .click       (click),
    .reset       (reset),
    .cap_en      (cap_en),
    .clear       (clear),
    .PCWre       (PCWre),
    .RegWre      (RegWre),
    .PC          (PC),
    .instruction (instruction),
    .write_data  (write_data),
    .rd          (rd_if.master),
    .count       (count),
    .full        (full),
    .overflow    (overflow)
  );

  initial click = 1'b0;
  always #5 click = ~click;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance one rising edge; inputs are driven and outputs sampled 1ns later
  task automatic cycle();
    @(posedge click);
    #1;
  endtask

  task automatic set_cap(input logic [31:0] pc, input logic [31:0] ins,
                         input logic [31:0] wd, input logic rw);
    PCWre       = 1'b1;
    PC          = pc;
    instruction = ins;
    write_data  = wd;
    RegWre      = rw;
  endtask

  task automatic check_word(input string tag, input logic [31:0] data,
                            input logic [1:0] word, input logic last);
    check({tag, ".valid"}, {31'b0, rd_if.rd_valid}, 32'd1);
    check({tag, ".data"},  rd_if.rd_data, data);
    check({tag, ".word"},  {30'b0, rd_if.rd_word}, {30'b0, word});
    check({tag, ".last"},  {31'b0, rd_if.rd_last}, {31'b0, last});
  endtask

  initial begin
    n_pass = 0;
    n_total = 0;
    reset = 1'b1;
    cap_en = 1'b0;
    clear = 1'b0;
    PCWre = 1'b0;
    RegWre = 1'b0;
    PC = '0;
    instruction = '0;
    write_data = '0;
    rd_if.rd_ready = 1'b0;

    cycle();
    cycle();
    reset = 1'b0;
    cycle();

    // ---- reset state
    check("rst.valid", {31'b0, rd_if.rd_valid}, 32'd0);
    check("rst.data",  rd_if.rd_data, 32'd0);
    check("rst.word",  {30'b0, rd_if.rd_word}, 32'd0);
    check("rst.last",  {31'b0, rd_if.rd_last}, 32'd0);
    check("rst.count", {27'b0, count}, 32'd0);
    check("rst.full",  {31'b0, full}, 32'd0);
    check("rst.ovf",   {31'b0, overflow}, 32'd0);

    // ---- cap_en low: nothing captured
    set_cap(32'h10, 32'h11, 32'h12, 1'b1);
    cycle();
    PCWre = 1'b0;
    check("capoff.count", {27'b0, count}, 32'd0);
    cycle();
    check("capoff.valid", {31'b0, rd_if.rd_valid}, 32'd0);

    // ---- single entry, reader always ready
    cap_en = 1'b1;
    rd_if.rd_ready = 1'b1;
    set_cap(32'h4, 32'h02221800, 32'h5, 1'b1);
    cycle();
    PCWre = 1'b0;
    check("one.count1", {27'b0, count}, 32'd1);
    check("one.nolat",  {31'b0, rd_if.rd_valid}, 32'd0);
    cycle();
    check_word("one.w0", 32'h4, 2'd0, 1'b0);
    cycle();
    check_word("one.w1", 32'h02221800, 2'd1, 1'b0);
    cycle();
    check_word("one.w2", 32'h5, 2'd2, 1'b1);
    check("one.count_w2", {27'b0, count}, 32'd1);
    cycle();
    check("one.idle", {31'b0, rd_if.rd_valid}, 32'd0);
    check("one.count0", {27'b0, count}, 32'd0);

    // ---- RegWre=0 masks write_data; ready toggled so each word is held
    rd_if.rd_ready = 1'b0;
    set_cap(32'h8, 32'h0000AAAA, 32'h1234, 1'b0);
    cycle();
    PCWre = 1'b0;
    cycle();
    check_word("tog.w0", 32'h8, 2'd0, 1'b0);
    cycle();
    check_word("tog.w0hold", 32'h8, 2'd0, 1'b0);
    rd_if.rd_ready = 1'b1;
    cycle();
    check_word("tog.w1", 32'h0000AAAA, 2'd1, 1'b0);
    rd_if.rd_ready = 1'b0;
    cycle();
    check_word("tog.w1hold", 32'h0000AAAA, 2'd1, 1'b0);
    rd_if.rd_ready = 1'b1;
    cycle();
    check_word("tog.w2", 32'h0, 2'd2, 1'b1);
    rd_if.rd_ready = 1'b0;
    cycle();
    check_word("tog.w2hold", 32'h0, 2'd2, 1'b1);
    rd_if.rd_ready = 1'b1;
    cycle();
    check("tog.idle", {31'b0, rd_if.rd_valid}, 32'd0);
    check("tog.count", {27'b0, count}, 32'd0);

    // ---- 17 pushes with reader stalled: 17th dropped, overflow set
    rd_if.rd_ready = 1'b0;
    for (int i = 0; i < 17; i++) begin
      set_cap(32'h100 + i, 32'h1000 + i, 32'h2000 + i, 1'b1);
      cycle();
    end
    PCWre = 1'b0;
    check("ovf.count", {27'b0, count}, 32'd16);
    check("ovf.full",  {31'b0, full}, 32'd1);
    check("ovf.flag",  {31'b0, overflow}, 32'd1);
    rd_if.rd_ready = 1'b1;
    for (int e = 0; e < 16; e++) begin
      check("ovf.drain_pc", rd_if.rd_data, 32'h100 + e);
      check("ovf.drain_word", {30'b0, rd_if.rd_word}, 32'd0);
      cycle();
      cycle();
      check("ovf.drain_wd", rd_if.rd_data, 32'h2000 + e);
      cycle();
    end
    check("ovf.empty_valid", {31'b0, rd_if.rd_valid}, 32'd0);
    check("ovf.empty_count", {27'b0, count}, 32'd0);

    // ---- clear with a same-cycle capture while entries are queued
    rd_if.rd_ready = 1'b0;
    set_cap(32'h500, 32'h501, 32'h502, 1'b1);
    cycle();
    cycle();
    check("clr.pre_count", {27'b0, count}, 32'd2);
    clear = 1'b1;
    set_cap(32'h600, 32'h601, 32'h602, 1'b1);
    cycle();
    clear = 1'b0;
    PCWre = 1'b0;
    check("clr.count", {27'b0, count}, 32'd0);
    check("clr.valid", {31'b0, rd_if.rd_valid}, 32'd0);
    check("clr.ovf",   {31'b0, overflow}, 32'd0);
    cycle();
    check("clr.after_count", {27'b0, count}, 32'd0);
    check("clr.after_valid", {31'b0, rd_if.rd_valid}, 32'd0);

    // ---- full queue, W2 handshake with same-edge push
    for (int i = 0; i < 16; i++) begin
      set_cap(32'h200 + i, 32'h3000 + i, 32'h4000 + i, 1'b1);
      cycle();
    end
    PCWre = 1'b0;
    check("fpp.full_pre", {31'b0, full}, 32'd1);
    rd_if.rd_ready = 1'b1;
    cycle();
    cycle();
    check_word("fpp.w2", 32'h4000, 2'd2, 1'b1);
    set_cap(32'h300, 32'h301, 32'h302, 1'b1);
    cycle();
    PCWre = 1'b0;
    check("fpp.count", {27'b0, count}, 32'd16);
    check("fpp.ovf",   {31'b0, overflow}, 32'd0);
    check("fpp.full",  {31'b0, full}, 32'd1);
    for (int e = 0; e < 16; e++) begin
      check("fpp.drain_pc", rd_if.rd_data, (e < 15) ? (32'h201 + e) : 32'h300);
      cycle();
      cycle();
      cycle();
    end
    check("fpp.empty_count", {27'b0, count}, 32'd0);
    check("fpp.empty_valid", {31'b0, rd_if.rd_valid}, 32'd0);

    // ---- asynchronous reset mid-stream (during W1)
    set_cap(32'h40, 32'h41, 32'h42, 1'b1);
    cycle();
    PCWre = 1'b0;
    cycle();
    cycle();
    check_word("ars.w1", 32'h41, 2'd1, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    check("ars.valid", {31'b0, rd_if.rd_valid}, 32'd0);
    check("ars.data",  rd_if.rd_data, 32'd0);
    check("ars.word",  {30'b0, rd_if.rd_word}, 32'd0);
    check("ars.last",  {31'b0, rd_if.rd_last}, 32'd0);
    check("ars.count", {27'b0, count}, 32'd0);
    cycle();
    reset = 1'b0;
    set_cap(32'h50, 32'h51, 32'h52, 1'b1);
    cycle();
    PCWre = 1'b0;
    cycle();
    check_word("ars.restream", 32'h50, 2'd0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
